// File: rtl/mk_fifo.sv
// Guarded two-port FIFO: enqueue and dequeue sides gated by ready flags,
// no bypass, sticky error on any request made while not ready.
module mk_fifo #(
  parameter int width = 1,
  parameter int depth = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [width-1:0]             enq_in,
  input  logic                         enq_en,
  output logic                         enq_rdy,
  output logic [width-1:0]             deq_out,
  input  logic                         deq_en,
  output logic                         deq_rdy,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         err
);
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d;
  logic             full, empty, enq_acc, deq_acc;

  // Extra pointer MSB separates the full and empty cases when the low bits match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    enq_acc  = enq_en && !full;
    deq_acc  = deq_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    if (enq_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq_acc) rd_ptr_d = rd_ptr_q + PW'(1);
    if ((enq_en && full) || (deq_en && empty)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately unreset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (enq_acc) mem_q[wr_ptr_q[AW-1:0]] <= enq_in;
  end

  assign enq_rdy = !full;
  assign deq_rdy = !empty;
  assign deq_out = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign count   = CW'(wr_ptr_q - rd_ptr_q);
  assign err     = err_q;
endmodule

// File: tb/tb_mk_fifo.sv
// Randomized and directed bench for mk_fifo: queue reference model plus a
// scoreboard drained by a negedge monitor.
module tb_mk_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] enq_in = '0;
  logic       enq_en = 1'b0;
  logic       enq_rdy;
  logic [7:0] deq_out;
  logic       deq_en = 1'b0;
  logic       deq_rdy;
  logic [2:0] count;
  logic       err;

  logic [0:0] enq_in1 = '0;
  logic       enq_en1 = 1'b0;
  logic       enq_rdy1;
  logic [0:0] deq_out1;
  logic       deq_en1 = 1'b0;
  logic       deq_rdy1;
  logic [1:0] count1;
  logic       err1;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];   // reference contents, oldest first
  logic [7:0] sbq[$];  // expected dequeue data
  logic       err_m = 1'b0;

  mk_fifo #(.width(8), .depth(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .enq_in(enq_in), .enq_en(enq_en), .enq_rdy(enq_rdy),
    .deq_out(deq_out), .deq_en(deq_en), .deq_rdy(deq_rdy),
    .count(count), .err(err)
  );

  mk_fifo #(.width(1), .depth(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .enq_in(enq_in1), .enq_en(enq_en1), .enq_rdy(enq_rdy1),
    .deq_out(deq_out1), .deq_en(deq_en1), .deq_rdy(deq_rdy1),
    .count(count1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // One clock of stimulus on u0; the model applies the acceptance rules to
  // the occupancy seen before the edge.
  task automatic step(input logic e, input logic [7:0] d, input logic q);
    int sz;
    enq_en = e; enq_in = d; deq_en = q;
    @(posedge clk);
    sz = mq.size();
    if ((e && sz >= 4) || (q && sz == 0)) err_m = 1'b1;
    if (q && sz > 0) void'(mq.pop_front());
    if (e && sz < 4) begin
      mq.push_back(d);
      sbq.push_back(d);
    end
    #1;
    enq_en = 1'b0; deq_en = 1'b0;
  endtask

  task automatic step1(input logic e, input logic d, input logic q);
    enq_en1 = e; enq_in1 = d; deq_en1 = q;
    @(posedge clk);
    #1;
    enq_en1 = 1'b0; deq_en1 = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [7:0] exp_d;
    chk("count",   32'(count),   32'(mq.size()));
    chk("enq_rdy", 32'(enq_rdy), 32'(mq.size() < 4));
    chk("deq_rdy", 32'(deq_rdy), 32'(mq.size() > 0));
    chk("head",    32'(deq_out), 32'((mq.size() > 0) ? mq[0] : 8'h00));
    chk("err",     32'(err),     32'(err_m));
    if (deq_en && deq_rdy) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: got dequeue of %0h want none", deq_out);
      end else begin
        exp_d = sbq.pop_front();
        chk("deq_data", 32'(deq_out), 32'(exp_d));
      end
    end
  end

  initial begin
    // Reset held across edges with a request pending: nothing may be written.
    enq_en = 1'b1; enq_in = 8'h99;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enq_rdy", 32'(enq_rdy), 32'd1);
    chk("rst_deq_rdy", 32'(deq_rdy), 32'd0);
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_deq_out", 32'(deq_out), 32'd0);
    chk("rst_err",     32'(err),     32'd0);
    enq_en = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill and drain.
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
    chk("fill_enq_rdy", 32'(enq_rdy), 32'd0);
    chk("fill_count",   32'(count),   32'd4);
    chk("fill_head",    32'(deq_out), 32'h11);
    step(0, 8'h00, 1); chk("drain_1", 32'(deq_out), 32'h22);
    step(0, 8'h00, 1); chk("drain_2", 32'(deq_out), 32'h33);
    step(0, 8'h00, 1); chk("drain_3", 32'(deq_out), 32'h44);
    step(0, 8'h00, 1);
    chk("drain_out",   32'(deq_out), 32'd0);
    chk("drain_rdy",   32'(deq_rdy), 32'd0);
    chk("drain_count", 32'(count),   32'd0);

    // Steady-state simultaneous enqueue/dequeue; pointers wrap past 2*depth.
    step(1, 8'hA0, 0); step(1, 8'hA1, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 8'(8'hA2 + i), 1);
      chk("simul_count", 32'(count), 32'd2);
    end
    chk("simul_err", 32'(err), 32'd0);

    // Full boundary: enqueue refused although a dequeue is accepted.
    step(1, 8'hB0, 0); step(1, 8'hB1, 0);
    step(1, 8'h55, 1);
    chk("full_count", 32'(count), 32'd3);
    chk("full_err",   32'(err),   32'd1);
    repeat (3) step(0, 8'h00, 1);

    // Async reset pulse mid-cycle with three entries held.
    step(1, 8'hC0, 0); step(1, 8'hC1, 0); step(1, 8'hC2, 0);
    #1 rst_n = 1'b0;
    mq.delete(); sbq.delete(); err_m = 1'b0;
    #1;
    chk("arst_enq_rdy", 32'(enq_rdy), 32'd1);
    chk("arst_deq_rdy", 32'(deq_rdy), 32'd0);
    chk("arst_count",   32'(count),   32'd0);
    chk("arst_deq_out", 32'(deq_out), 32'd0);
    chk("arst_err",     32'(err),     32'd0);
    enq_en = 1'b1; enq_in = 8'h77;
    #4 rst_n = 1'b1; enq_en = 1'b0;
    @(posedge clk); #1;
    chk("arst_no_write", 32'(count), 32'd0);

    // Empty boundary: dequeue refused, enqueue accepted, no bypass.
    step(1, 8'h66, 1);
    chk("empty_count", 32'(count),   32'd1);
    chk("empty_head",  32'(deq_out), 32'h66);
    chk("empty_err",   32'(err),     32'd1);
    step(0, 8'h00, 1);

    // Random traffic alternating between enqueue-heavy and dequeue-heavy runs.
    for (int i = 0; i < 400; i++) begin
      int p;
      p = ((i / 25) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < p, 8'($urandom), $urandom_range(0, 99) >= p);
    end

    // Narrow, shallow instance.
    step1(1, 1'b1, 0); step1(1, 1'b0, 0); step1(1, 1'b1, 0);
    chk("n_count",   32'(count1),   32'd2);
    chk("n_err",     32'(err1),     32'd1);
    chk("n_enq_rdy", 32'(enq_rdy1), 32'd0);
    chk("n_head0",   32'(deq_out1), 32'd1);
    step1(0, 1'b0, 1);
    chk("n_head1",   32'(deq_out1), 32'd0);
    chk("n_count1",  32'(count1),   32'd1);
    step1(0, 1'b0, 1);
    chk("n_deq_rdy", 32'(deq_rdy1), 32'd0);
    chk("n_count0",  32'(count1),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
